// File: rtl/neo_pkg.sv
// Shared types and helpers for the nonlinear energy operator engine.
package neo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } neo_state_t;

  function automatic int psi_width(input int n);
    return 2 * n + 1;
  endfunction

endpackage

// File: rtl/neo_mac.sv
// Two-stage registered datapath: stage 1 forms x1*x1 and x0*x2, stage 2 subtracts them.
module neo_mac
  import neo_pkg::*;
#(
  parameter int N     = 16,
  parameter int PSI_W = psi_width(N)
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic signed [N-1:0]     i_x0,
  input  logic signed [N-1:0]     i_x1,
  input  logic signed [N-1:0]     i_x2,
  input  logic                    i_valid,
  output logic signed [PSI_W-1:0] o_psi,
  output logic                    o_valid,
  output logic                    o_s1_valid
);

  logic signed [2*N-1:0]   r_sq;
  logic signed [2*N-1:0]   r_cr;
  logic                    r_v1;
  logic signed [PSI_W-1:0] r_psi;
  logic                    r_v2;
  logic signed [2*N-1:0]   w_sq;
  logic signed [2*N-1:0]   w_cr;
  logic signed [PSI_W-1:0] w_diff;

  // Sign-extended operands keep both products exact; the extra psi bit absorbs the subtraction.
  assign w_sq   = (2*N)'(i_x1) * (2*N)'(i_x1);
  assign w_cr   = (2*N)'(i_x0) * (2*N)'(i_x2);
  assign w_diff = PSI_W'(r_sq) - PSI_W'(r_cr);

  // Pipeline registers; data only advances alongside its valid so psi holds after a sweep.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sq  <= '0;
      r_cr  <= '0;
      r_v1  <= 1'b0;
      r_psi <= '0;
      r_v2  <= 1'b0;
    end else begin
      r_v1 <= i_valid;
      r_v2 <= r_v1;
      if (i_valid) begin
        r_sq <= w_sq;
        r_cr <= w_cr;
      end
      if (r_v1) begin
        r_psi <= w_diff;
      end
    end
  end

  assign o_psi      = r_psi;
  assign o_valid    = r_v2;
  assign o_s1_valid = r_v1;

endmodule

// File: rtl/neo_engine.sv
// Sweeps sample memory, forms the NEO psi[n] over a 3-sample window and counts threshold crossings.
module neo_engine
  import neo_pkg::*;
#(
  parameter int N     = 16,
  parameter int M     = 16,
  parameter int AW    = $clog2(M) + 1,
  parameter int PSI_W = psi_width(N)
) (
  input  logic                    Clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic signed [PSI_W-1:0] thresh,
  output logic [AW-1:0]           raddr,
  input  logic signed [N-1:0]     rdata,
  output logic signed [PSI_W-1:0] psi,
  output logic                    psi_valid,
  output logic                    spike,
  output logic [AW-1:0]           spike_cnt,
  output logic                    busy,
  output logic                    done
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(M - 1);

  neo_state_t              r_state;
  neo_state_t              w_next;
  logic [AW-1:0]           r_raddr;
  logic                    r_rvalid;
  logic signed [N-1:0]     r_x0;
  logic signed [N-1:0]     r_x1;
  logic signed [N-1:0]     r_x2;
  logic [1:0]              r_fill;
  logic                    r_win_vld;
  logic signed [PSI_W-1:0] r_thresh;
  logic [AW-1:0]           r_cnt;
  logic                    r_busy;
  logic                    r_done;
  logic                    w_start;
  logic signed [PSI_W-1:0] w_psi;
  logic                    w_psi_valid;
  logic                    w_s1_valid;
  logic                    w_spike;

  assign w_start = (r_state == IDLE) && start;

  // Next-state logic; DRAIN ends on the final result, when stage 1 has nothing behind it.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = FETCH; else w_next = IDLE;
      FETCH:   if (r_raddr == LAST_ADDR) w_next = DRAIN; else w_next = FETCH;
      DRAIN:   if (w_psi_valid && !w_s1_valid) w_next = DONE; else w_next = DRAIN;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_raddr  <= '0;
      r_rvalid <= 1'b0;
      r_thresh <= '0;
    end else begin
      r_state  <= w_next;
      r_busy   <= (w_next == FETCH) || (w_next == DRAIN);
      r_done   <= (w_next == DONE);
      // rdata carries a fetched sample the cycle after each FETCH address.
      r_rvalid <= (r_state == FETCH);
      if (w_start) begin
        r_raddr  <= '0;
        r_thresh <= thresh;
      end else if ((r_state == FETCH) && (r_raddr != LAST_ADDR)) begin
        r_raddr <= r_raddr + AW'(1);
      end
    end
  end

  // Sample window; the window is complete once three samples have shifted in.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      r_x0      <= '0;
      r_x1      <= '0;
      r_x2      <= '0;
      r_fill    <= 2'd0;
      r_win_vld <= 1'b0;
    end else begin
      if (w_start) begin
        r_fill <= 2'd0;
      end else if (r_rvalid) begin
        r_fill <= (r_fill == 2'd2) ? 2'd2 : r_fill + 2'd1;
      end
      r_win_vld <= r_rvalid && (r_fill == 2'd2);
      if (r_rvalid) begin
        r_x2 <= rdata;
        r_x1 <= r_x2;
        r_x0 <= r_x1;
      end
    end
  end

  neo_mac #(
    .N     (N),
    .PSI_W (PSI_W)
  ) u_mac (
    .i_clk      (Clk),
    .i_rst_n    (reset),
    .i_x0       (r_x0),
    .i_x1       (r_x1),
    .i_x2       (r_x2),
    .i_valid    (r_win_vld),
    .o_psi      (w_psi),
    .o_valid    (w_psi_valid),
    .o_s1_valid (w_s1_valid)
  );

  assign w_spike = w_psi_valid && (w_psi > r_thresh);

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (w_start) begin
      r_cnt <= '0;
    end else if (w_spike) begin
      r_cnt <= r_cnt + AW'(1);
    end
  end

  assign raddr     = r_raddr;
  assign psi       = w_psi;
  assign psi_valid = w_psi_valid;
  assign spike     = w_spike;
  assign spike_cnt = r_cnt;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_neo_engine.sv
// Directed bench for neo_engine: vector table of memory images with hand-computed psi and spike counts.
module tb_neo_engine;

  logic               Clk = 1'b0;
  logic               reset = 1'b0;
  logic               start = 1'b0;
  logic signed [32:0] thresh = 33'sd0;
  logic [4:0]         raddr;
  logic signed [15:0] rdata = 16'sd0;
  logic signed [32:0] psi;
  logic               psi_valid;
  logic               spike;
  logic [4:0]         spike_cnt;
  logic               busy;
  logic               done;

  logic signed [15:0] mem [16];
  int n_tests = 0;
  int n_fail  = 0;

  neo_engine dut (
    .Clk       (Clk),
    .reset     (reset),
    .start     (start),
    .thresh    (thresh),
    .raddr     (raddr),
    .rdata     (rdata),
    .psi       (psi),
    .psi_valid (psi_valid),
    .spike     (spike),
    .spike_cnt (spike_cnt),
    .busy      (busy),
    .done      (done)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) rdata <= mem[raddr[3:0]];

  typedef struct {
    string  name;
    int     m0, m1, m2, a, b;
    longint th, e_psi1, e_psi2;
    int     e_cnt;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic longint model(input int n);
    return longint'(mem[n]) * longint'(mem[n]) - longint'(mem[n-1]) * longint'(mem[n+1]);
  endfunction

  task automatic fill(input vec_t v);
    mem[0] = 16'(v.m0);
    mem[1] = 16'(v.m1);
    mem[2] = 16'(v.m2);
    for (int k = 3; k < 16; k++) mem[k] = 16'(v.a + v.b * k);
  endtask

  task automatic run_sweep(input string tag, input longint th, input bit poke,
                           output longint p1, output longint p2, output int cnt);
    int nv, ndone, first_i, done_i;
    longint ex;
    nv = 0; ndone = 0; first_i = -1; done_i = -1; p1 = 0; p2 = 0;
    @(negedge Clk);
    thresh = 33'(th);
    start  = 1'b1;
    @(posedge Clk); #1;
    start  = 1'b0;
    thresh = {1'b0, {32{1'b1}}};
    chk({tag, " busy"}, longint'(busy), 1);
    for (int i = 1; i <= 40; i++) begin
      if (poke && i == 10) start = 1'b1;
      @(posedge Clk); #1;
      if (poke && i == 10) start = 1'b0;
      if (psi_valid) begin
        nv++;
        if (first_i < 0) first_i = i;
        ex = model(nv);
        chk({tag, " psi"}, longint'(psi), ex);
        chk({tag, " spike"}, longint'(spike), longint'(ex > th));
        if (nv == 1) p1 = psi;
        if (nv == 2) p2 = psi;
      end else begin
        chk({tag, " spike w/o valid"}, longint'(spike), 0);
      end
      if (done) begin
        ndone++;
        if (done_i < 0) done_i = i;
      end
    end
    cnt = int'(spike_cnt);
    chk({tag, " valid count"}, nv, 14);
    chk({tag, " done pulses"}, ndone, 1);
    chk({tag, " first valid edge"}, first_i, 6);
    chk({tag, " done edge"}, done_i, 20);
    chk({tag, " valid idle"}, longint'(psi_valid), 0);
    chk({tag, " psi hold"}, longint'(psi), model(14));
    chk({tag, " busy idle"}, longint'(busy), 0);
  endtask

  initial begin
    longint p1, p2;
    int cnt, nv;

    vecs[0] = '{"ramp",      0,      1,      2,      0, 1, 0,          1,          1,          14};
    vecs[1] = '{"const",     5,      5,      5,      5, 0, 0,          0,          0,          0};
    vecs[2] = '{"const_neg", 5,      5,      5,      5, 0, -1,         0,          0,          14};
    vecs[3] = '{"ramp_eq",   0,      1,      2,      0, 1, 1,          1,          1,          0};
    vecs[4] = '{"signed",    -3,     4,      -3,     0, 0, 0,          7,          9,          2};
    vecs[5] = '{"ext1",      -32768, 32767,  -32768, 0, 0, 0,          -65535,     1073741824, 1};
    vecs[6] = '{"ext2",      -32768, -32768, 32767,  0, 0, 2147450879, 2147450880, 1073676289, 1};

    for (int k = 0; k < 16; k++) mem[k] = 16'sd0;

    #12;
    chk("reset psi_valid", longint'(psi_valid), 0);
    chk("reset done", longint'(done), 0);
    chk("reset busy", longint'(busy), 0);
    chk("reset raddr", longint'(raddr), 0);
    chk("reset spike_cnt", longint'(spike_cnt), 0);
    chk("reset psi", longint'(psi), 0);
    @(negedge Clk);
    reset = 1'b1;
    repeat (2) @(negedge Clk);

    for (int v = 0; v < 7; v++) begin
      fill(vecs[v]);
      run_sweep(vecs[v].name, vecs[v].th, (v == 0), p1, p2, cnt);
      chk({vecs[v].name, " psi1"}, p1, vecs[v].e_psi1);
      chk({vecs[v].name, " psi2"}, p2, vecs[v].e_psi2);
      chk({vecs[v].name, " spike_cnt"}, cnt, vecs[v].e_cnt);
    end

    // Reset during the fifth result of a ramp sweep.
    fill(vecs[0]);
    @(negedge Clk);
    thresh = 33'sd0;
    start  = 1'b1;
    @(posedge Clk); #1;
    start  = 1'b0;
    nv = 0;
    for (int i = 1; i <= 30; i++) begin
      @(posedge Clk); #1;
      if (psi_valid) nv++;
      if (nv == 5) break;
    end
    chk("rst reached 5th valid", nv, 5);
    #2;
    reset = 1'b0;
    #1;
    chk("rst async psi_valid", longint'(psi_valid), 0);
    chk("rst async spike", longint'(spike), 0);
    chk("rst async psi", longint'(psi), 0);
    chk("rst async spike_cnt", longint'(spike_cnt), 0);
    chk("rst async busy", longint'(busy), 0);
    chk("rst async raddr", longint'(raddr), 0);
    repeat (3) @(negedge Clk);
    reset = 1'b1;
    nv = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge Clk); #1;
      if (psi_valid || done) nv++;
    end
    chk("post-rst quiet", nv, 0);
    run_sweep("after_rst", 0, 1'b0, p1, p2, cnt);
    chk("after_rst psi1", p1, 1);
    chk("after_rst spike_cnt", cnt, 14);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
